// File: rtl/ann_layer_sequencer_if.sv
// Handshake and address bundle between the ANN layer sequencer, the ANN
// controller (start/busy/layer_done) and the neuron MAC datapath.
// The master modport is the sequencer side; slave is the environment side.
interface ann_layer_sequencer_if #(
   parameter int CNT_W  = 7,
   parameter int ADDR_W = 12
);
   logic              start;
   logic [1:0]        layer_idx;
   logic              mac_ready;
   logic              op_valid;
   logic [CNT_W-1:0]  in_addr;
   logic [ADDR_W-1:0] w_addr;
   logic              clear_accum;
   logic              store_result;
   logic [CNT_W-1:0]  out_addr;
   logic              busy;
   logic              layer_done;

   modport master (
      input  start, layer_idx, mac_ready,
      output op_valid, in_addr, w_addr, clear_accum, store_result,
             out_addr, busy, layer_done
   );

   modport slave (
      output start, layer_idx, mac_ready,
      input  op_valid, in_addr, w_addr, clear_accum, store_result,
             out_addr, busy, layer_done
   );
endinterface

// File: rtl/ann_layer_sequencer.sv
// Walks every (neuron, input) pair of one ANN layer, issuing operand
// addresses to the MAC, then clears/stores the accumulator per neuron.
// The coefficient address is a running pointer, so no multiplier is needed.
module ann_layer_sequencer #(
   parameter int ADDR_W  = 12,
   parameter int CNT_W   = 7,
   parameter int MAC_LAT = 2
) (
   input logic clk,
   input logic n_rst,
   ann_layer_sequencer_if.master bus
);
   typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, STORE, DONE} state_t;

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  i_cnt;
   logic [CNT_W-1:0]  n_cnt;
   logic [CNT_W-1:0]  last_in;
   logic [CNT_W-1:0]  last_out;
   logic [ADDR_W-1:0] ptr;
   logic [2:0]        drain_cnt;
   logic [CNT_W-1:0]  tbl_last_in;
   logic [CNT_W-1:0]  tbl_last_out;
   logic [ADDR_W-1:0] tbl_base;
   logic              xfer;
   logic              last_input;
   logic              last_neuron;
   logic              drain_end;

   assign xfer        = (state == ISSUE) && bus.mac_ready;
   assign last_input  = (i_cnt == last_in);
   assign last_neuron = (n_cnt == last_out);
   assign drain_end   = (drain_cnt == 3'(MAC_LAT - 1));

   // Fixed layer table; counts are held as "last index" (N-1) so the
   // end-of-row and end-of-layer tests are plain equality compares.
   always_comb begin
      tbl_last_in  = CNT_W'(15);
      tbl_last_out = CNT_W'(9);
      tbl_base     = ADDR_W'(2816);
      case (bus.layer_idx)
         2'd0: begin
            tbl_last_in  = CNT_W'(63);
            tbl_last_out = CNT_W'(31);
            tbl_base     = ADDR_W'(0);
         end
         2'd1: begin
            tbl_last_in  = CNT_W'(31);
            tbl_last_out = CNT_W'(15);
            tbl_base     = ADDR_W'(2048);
         end
         2'd2: begin
            tbl_last_in  = CNT_W'(15);
            tbl_last_out = CNT_W'(15);
            tbl_base     = ADDR_W'(2560);
         end
         default: begin
            tbl_last_in  = CNT_W'(15);
            tbl_last_out = CNT_W'(9);
            tbl_base     = ADDR_W'(2816);
         end
      endcase
   end

   // State register; reset aborts any running layer without a done pulse.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; start is only looked at in IDLE, so it is ignored while busy.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = CLEAR;
         CLEAR:   state_next = ISSUE;
         ISSUE:   if (xfer && last_input) state_next = DRAIN;
         DRAIN:   if (drain_end) state_next = STORE;
         STORE:   state_next = last_neuron ? DONE : CLEAR;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Moore outputs; addresses are zeroed outside their strobe so idle is all-zero.
   always_comb begin
      bus.clear_accum  = (state == CLEAR);
      bus.op_valid     = (state == ISSUE);
      bus.store_result = (state == STORE);
      bus.layer_done   = (state == DONE);
      bus.busy         = (state != IDLE);
      bus.in_addr      = (state == ISSUE) ? i_cnt : '0;
      bus.w_addr       = (state == ISSUE) ? ptr : '0;
      bus.out_addr     = (state == STORE) ? n_cnt : '0;
   end

   // Index counters, coefficient pointer and MAC latency counter; the layer
   // table entry is latched at start so later layer_idx changes do nothing.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         i_cnt     <= '0;
         n_cnt     <= '0;
         last_in   <= '0;
         last_out  <= '0;
         ptr       <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  i_cnt    <= '0;
                  n_cnt    <= '0;
                  ptr      <= tbl_base;
                  last_in  <= tbl_last_in;
                  last_out <= tbl_last_out;
               end
            end
            CLEAR: begin
               i_cnt     <= '0;
               drain_cnt <= '0;
            end
            ISSUE: begin
               if (xfer) begin
                  ptr <= ptr + 1'b1;
                  if (!last_input) i_cnt <= i_cnt + 1'b1;
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + 3'd1;
            end
            STORE: begin
               if (!last_neuron) n_cnt <= n_cnt + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Self-checking bench for ann_layer_sequencer: table of whole-layer runs
// scored against an address model, plus a hand-written mid-layer reset.
module tb_ann_layer_sequencer;
   localparam int ADDR_W  = 12;
   localparam int CNT_W   = 7;
   localparam int MAC_LAT = 2;

   logic clk = 1'b0;
   logic n_rst;

   ann_layer_sequencer_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

   ann_layer_sequencer #(
      .ADDR_W(ADDR_W),
      .CNT_W(CNT_W),
      .MAC_LAT(MAC_LAT)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int in_addr;
      int w_addr;
   } xfer_t;

   typedef struct {
      int layer;
      int stall;
      int restart_at;
      int restart_layer;
      int exp_xfers;
      int exp_stores;
      int exp_clears;
      int exp_last_w;
      int exp_cycles;
   } vec_t;

   int lt_n_in[4]  = '{64, 32, 16, 16};
   int lt_n_out[4] = '{32, 16, 16, 10};
   int lt_base[4]  = '{0, 2048, 2560, 2816};

   xfer_t xfer_q[$];
   int    store_q[$];
   int    n_checks = 0;
   int    n_pass = 0;
   vec_t  vecs[5];

   task automatic check_output(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Advance one clock, then drive inputs for the new cycle (outputs are settled here).
   task automatic apply_stimulus(input bit s, input int l, input bit r);
      @(posedge clk);
      #1;
      bus.start     = s;
      bus.layer_idx = 2'(l);
      bus.mac_ready = r;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_output({tag, "_op_valid"}, int'(bus.op_valid), 0);
      check_output({tag, "_in_addr"}, int'(bus.in_addr), 0);
      check_output({tag, "_w_addr"}, int'(bus.w_addr), 0);
      check_output({tag, "_clear"}, int'(bus.clear_accum), 0);
      check_output({tag, "_store"}, int'(bus.store_result), 0);
      check_output({tag, "_out_addr"}, int'(bus.out_addr), 0);
      check_output({tag, "_busy"}, int'(bus.busy), 0);
      check_output({tag, "_done"}, int'(bus.layer_done), 0);
   endtask

   task automatic run_layer(input vec_t v);
      int    n_in, n_out, base;
      int    cyc, xfers, stores, clears, last_w, done_cyc;
      int    onehot_bad, busy_bad, prev_in, prev_w, layer_sel;
      bit    prev_stalled, ready, start_now;
      xfer_t e;
      int    es;

      n_in  = lt_n_in[v.layer];
      n_out = lt_n_out[v.layer];
      base  = lt_base[v.layer];
      xfer_q.delete();
      store_q.delete();
      for (int n = 0; n < n_out; n++) begin
         for (int i = 0; i < n_in; i++) begin
            e.in_addr = i;
            e.w_addr  = base + n * n_in + i;
            xfer_q.push_back(e);
         end
         store_q.push_back(n);
      end

      apply_stimulus(1'b1, v.layer, 1'b1);
      cyc = 0; xfers = 0; stores = 0; clears = 0; last_w = -1; done_cyc = -1;
      onehot_bad = 0; busy_bad = 0; prev_stalled = 1'b0; prev_in = 0; prev_w = 0;
      while (cyc < 6000 && done_cyc < 0) begin
         ready     = (v.stall != 0) ? (cyc % 2 == 0) : 1'b1;
         start_now = (v.restart_at > 0) && (cyc + 1 == v.restart_at);
         layer_sel = ((v.restart_at > 0) && (cyc + 1 >= v.restart_at)) ? v.restart_layer : v.layer;
         apply_stimulus(start_now, layer_sel, ready);
         cyc++;
         if (bus.busy !== 1'b1) busy_bad++;
         if (int'(bus.clear_accum) + int'(bus.op_valid) + int'(bus.store_result) > 1) onehot_bad++;
         if (bus.clear_accum) clears++;
         if (bus.op_valid) begin
            if (prev_stalled) begin
               check_output("stall_hold_in", int'(bus.in_addr), prev_in);
               check_output("stall_hold_w", int'(bus.w_addr), prev_w);
            end
            prev_stalled = !ready;
            prev_in      = int'(bus.in_addr);
            prev_w       = int'(bus.w_addr);
            if (ready) begin
               xfers++;
               last_w = int'(bus.w_addr);
               if (xfer_q.size() == 0) begin
                  check_output("xfer_extra", 1, 0);
               end else begin
                  e = xfer_q.pop_front();
                  check_output("xfer_in", int'(bus.in_addr), e.in_addr);
                  check_output("xfer_w", int'(bus.w_addr), e.w_addr);
               end
            end
         end else begin
            prev_stalled = 1'b0;
         end
         if (bus.store_result) begin
            stores++;
            if (store_q.size() == 0) begin
               check_output("store_extra", 1, 0);
            end else begin
               es = store_q.pop_front();
               check_output("out_addr", int'(bus.out_addr), es);
            end
         end
         if (bus.layer_done) done_cyc = cyc;
      end

      check_output("done_seen", int'(done_cyc >= 0), 1);
      if (v.exp_cycles > 0) check_output("duration", done_cyc, v.exp_cycles);
      check_output("xfer_count", xfers, v.exp_xfers);
      check_output("store_count", stores, v.exp_stores);
      check_output("clear_count", clears, v.exp_clears);
      check_output("last_w_addr", last_w, v.exp_last_w);
      check_output("xfer_q_left", xfer_q.size(), 0);
      check_output("onehot_bad", onehot_bad, 0);
      check_output("busy_bad", busy_bad, 0);
      apply_stimulus(1'b0, v.layer, 1'b1);
      check_output("busy_after_done", int'(bus.busy), 0);
      check_output("done_after_done", int'(bus.layer_done), 0);
   endtask

   initial begin
      int  rst_stores;
      bit  found;

      vecs[0] = '{layer: 3, stall: 0, restart_at: 0,  restart_layer: 0, exp_xfers: 160,
                  exp_stores: 10, exp_clears: 10, exp_last_w: 2975, exp_cycles: 201};
      vecs[1] = '{layer: 0, stall: 0, restart_at: 0,  restart_layer: 0, exp_xfers: 2048,
                  exp_stores: 32, exp_clears: 32, exp_last_w: 2047, exp_cycles: 2177};
      vecs[2] = '{layer: 2, stall: 1, restart_at: 0,  restart_layer: 0, exp_xfers: 256,
                  exp_stores: 16, exp_clears: 16, exp_last_w: 2815, exp_cycles: 0};
      vecs[3] = '{layer: 1, stall: 0, restart_at: 50, restart_layer: 0, exp_xfers: 512,
                  exp_stores: 16, exp_clears: 16, exp_last_w: 2559, exp_cycles: 577};
      vecs[4] = '{layer: 2, stall: 0, restart_at: 0,  restart_layer: 0, exp_xfers: 256,
                  exp_stores: 16, exp_clears: 16, exp_last_w: 2815, exp_cycles: 321};

      n_rst         = 1'b0;
      bus.start     = 1'b0;
      bus.layer_idx = 2'd0;
      bus.mac_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      n_rst = 1'b1;
      apply_stimulus(1'b0, 0, 1'b1);
      check_idle_outputs("idle");

      for (int k = 0; k < 5; k++) begin
         $display("[TB] vector %0d: layer %0d stall %0d restart_at %0d",
                  k, vecs[k].layer, vecs[k].stall, vecs[k].restart_at);
         run_layer(vecs[k]);
      end

      // Abort layer 1 while neuron 5 is issuing, then run layer 3 from scratch.
      apply_stimulus(1'b1, 1, 1'b1);
      rst_stores = 0;
      found = 1'b0;
      for (int c = 0; c < 2000 && !found; c++) begin
         apply_stimulus(1'b0, 1, 1'b1);
         if (bus.store_result) rst_stores++;
         if (rst_stores == 5 && bus.op_valid && bus.in_addr == 7'd3) found = 1'b1;
      end
      check_output("abort_reached_issue", int'(found), 1);
      check_output("abort_pre_w_addr", int'(bus.w_addr), 2048 + 5 * 32 + 3);
      #1 n_rst = 1'b0;
      #1;
      check_idle_outputs("abort");
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check_output("abort_no_done", int'(bus.layer_done), 0);
      end
      @(negedge clk);
      n_rst = 1'b1;
      apply_stimulus(1'b0, 0, 1'b1);
      check_output("abort_idle_busy", int'(bus.busy), 0);
      run_layer(vecs[0]);

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
